axis_pkt_arbiter: RTL and testbench

- Packet-level round-robin arbiter that shares one AXI-stream FIFO write port (fifo_top writeData/Valid/Ready/Last) between NumSrc stream sources, e.g. several counter_up generators.
- Grants one source at a time and holds the grant until that source's Last beat, so packets never interleave in the FIFO.
- Includes a per-packet beat limit. An over-length packet is truncated toward the FIFO, and its remainder is drained from the source.

---
 rtl/axis_pkt_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_axis_pkt_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-stream FIFO write port
// between NumSrc sources. A grant is held until the source's last beat, so
// packets never interleave. Packets longer than MaxPktBeats are cut at the
// limit toward the FIFO and the remainder is drained from the source.
// Optional build macro ARB_PKT_STATS_EN adds per-source packet counters (pktCount).
module axis_pkt_arbiter #(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned NumSrc      = 2,
  parameter int unsigned MaxPktBeats = 4096
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        arbEnable,
  input  logic [NumSrc*DataWidth-1:0] inData,
  input  logic [NumSrc-1:0]           inDataValid,
  output logic [NumSrc-1:0]           inDataReady,
  input  logic [NumSrc-1:0]           inDataLast,
  output logic [DataWidth-1:0]        outData,
  output logic                        outDataValid,
  input  logic                        outDataReady,
  output logic                        outDataLast,
  output logic [$clog2(NumSrc)-1:0]   grantIdx,
  output logic                        busy,
  output logic                        truncErr
`ifdef ARB_PKT_STATS_EN
  ,
  output logic [NumSrc*16-1:0]        pktCount
`endif
);

  localparam int unsigned IdxW = $clog2(NumSrc);
  localparam int unsigned CntW = $clog2(MaxPktBeats) + 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(MaxPktBeats - 1);
  localparam logic [IdxW-1:0] TopIdx   = IdxW'(NumSrc - 1);

  typedef enum logic [1:0] {StIdle, StXfer, StDrain} arbStateT;

  arbStateT            stateQ, stateD;
  logic [IdxW-1:0]     rrPtrQ, rrPtrD;
  logic [IdxW-1:0]     grantQ, grantD;
  logic [CntW-1:0]     beatCntQ, beatCntD;
  logic                truncQ, truncD;

  logic [IdxW-1:0]     pick;
  logic                pickValid;
  logic [IdxW:0]       scanIdx;
  logic [DataWidth-1:0] selData;
  logic                selValid;
  logic                selLast;
  logic                atLimit;
  logic                xferAcc;
  logic                drainAcc;
  logic [IdxW-1:0]     nextPtr;

  assign selValid = inDataValid[grantQ];
  assign selLast  = inDataLast[grantQ];
  assign atLimit  = (beatCntQ == LastBeat);
  assign xferAcc  = (stateQ == StXfer) && selValid && outDataReady;
  assign drainAcc = (stateQ == StDrain) && selValid;
  assign nextPtr  = (grantQ == TopIdx) ? '0 : grantQ + IdxW'(1);

  // Pick the first valid source at or above rrPtr, wrapping at NumSrc-1.
  always_comb begin
    pick      = rrPtrQ;
    pickValid = 1'b0;
    scanIdx   = '0;
    for (int unsigned i = 0; i < NumSrc; i++) begin
      scanIdx = {1'b0, rrPtrQ} + (IdxW + 1)'(i);
      if (scanIdx >= (IdxW + 1)'(NumSrc)) begin
        scanIdx = scanIdx - (IdxW + 1)'(NumSrc);
      end
      if (!pickValid && inDataValid[scanIdx[IdxW-1:0]]) begin
        pick      = scanIdx[IdxW-1:0];
        pickValid = 1'b1;
      end
    end
  end

  // Data mux for the granted source.
  always_comb begin
    selData = '0;
    for (int unsigned i = 0; i < NumSrc; i++) begin
      if (grantQ == IdxW'(i)) begin
        selData = inData[i*DataWidth +: DataWidth];
      end
    end
  end

  // State register and arbitration bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ   <= StIdle;
      rrPtrQ   <= '0;
      grantQ   <= '0;
      beatCntQ <= '0;
      truncQ   <= 1'b0;
    end else begin
      stateQ   <= stateD;
      rrPtrQ   <= rrPtrD;
      grantQ   <= grantD;
      beatCntQ <= beatCntD;
      truncQ   <= truncD;
    end
  end

  // Next-state logic: grant, forward until last or limit, drain remainder.
  always_comb begin
    stateD   = stateQ;
    rrPtrD   = rrPtrQ;
    grantD   = grantQ;
    beatCntD = beatCntQ;
    truncD   = truncQ;
    unique case (stateQ)
      StIdle: begin
        if (arbEnable && pickValid) begin
          grantD   = pick;
          beatCntD = '0;
          stateD   = StXfer;
        end
      end
      StXfer: begin
        if (xferAcc) begin
          beatCntD = beatCntQ + CntW'(1);
          if (selLast) begin
            rrPtrD = nextPtr;
            stateD = StIdle;
          end else if (atLimit) begin
            truncD = 1'b1;
            rrPtrD = nextPtr;
            stateD = StDrain;
          end
        end
      end
      StDrain: begin
        if (drainAcc && selLast) begin
          stateD = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  // Output decode: only the granted source ever sees ready.
  always_comb begin
    inDataReady  = '0;
    outData      = '0;
    outDataValid = 1'b0;
    outDataLast  = 1'b0;
    unique case (stateQ)
      StXfer: begin
        outData             = selData;
        outDataValid        = selValid;
        outDataLast         = selLast | atLimit;
        inDataReady[grantQ] = outDataReady;
      end
      StDrain: begin
        inDataReady[grantQ] = 1'b1;
      end
      default: ;
    endcase
  end

  assign grantIdx = grantQ;
  assign busy     = (stateQ != StIdle);
  assign truncErr = truncQ;

`ifdef ARB_PKT_STATS_EN
  logic [15:0] pktCntQ [NumSrc];
  logic        pktDone;

  // A packet completes on the beat that carries outDataLast, truncated or not.
  assign pktDone = xferAcc && (selLast || atLimit);

  // Per-source packet counters, wrapping at 16 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NumSrc; i++) begin
        pktCntQ[i] <= '0;
      end
    end else if (pktDone) begin
      pktCntQ[grantQ] <= pktCntQ[grantQ] + 16'd1;
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    pktCount = '0;
    for (int unsigned i = 0; i < NumSrc; i++) begin
      pktCount[i*16 +: 16] = pktCntQ[i];
    end
  end
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Self-checking bench for axis_pkt_arbiter (NumSrc=2, MaxPktBeats=16).
// Sources are modelled as beat queues; expected FIFO beats are queued in
// predicted round-robin order at load time and compared as they emerge.
module tb_axis_pkt_arbiter;

  localparam int unsigned DW   = 32;
  localparam int unsigned NS   = 2;
  localparam int unsigned MAXB = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             arbEnable = 1'b0;
  logic [NS*DW-1:0] inData = '0;
  logic [NS-1:0]    inDataValid = '0;
  logic [NS-1:0]    inDataReady;
  logic [NS-1:0]    inDataLast = '0;
  logic [DW-1:0]    outData;
  logic             outDataValid;
  logic             outDataReady = 1'b1;
  logic             outDataLast;
  logic             grantIdx;
  logic             busy;
  logic             truncErr;
`ifdef ARB_PKT_STATS_EN
  logic [NS*16-1:0] pktCount;
`endif

  always #5 clk = ~clk;

  axis_pkt_arbiter #(
    .DataWidth  (DW),
    .NumSrc     (NS),
    .MaxPktBeats(MAXB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .arbEnable   (arbEnable),
    .inData      (inData),
    .inDataValid (inDataValid),
    .inDataReady (inDataReady),
    .inDataLast  (inDataLast),
    .outData     (outData),
    .outDataValid(outDataValid),
    .outDataReady(outDataReady),
    .outDataLast (outDataLast),
    .grantIdx    (grantIdx),
    .busy        (busy),
    .truncErr    (truncErr)
`ifdef ARB_PKT_STATS_EN
    ,
    .pktCount    (pktCount)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [32:0] src0Q[$];
  logic [32:0] src1Q[$];
  logic [32:0] expQ[$];
  bit toggleRdy = 0;
  bit chkGap = 0;
  bit chkRdy = 0;
  bit expectFirst = 1;
  int prevLastCyc = -1;
  int firstBeatCyc = -1;
  int outBeats = 0;
  int bpLoadCyc = 0;

  // Beat encoding: {last, 8'h0, src, pkt, beat}.
  function automatic logic [32:0] mkBeat(input int src, input int pkt, input int b,
                                         input bit last);
    return {last, 8'h00, 8'(src), 8'(pkt), 8'(b)};
  endfunction

  task automatic loadPkt(input int src, input int pkt, input int len, input bit toSrc,
                         input bit toExp);
    int fwd;
    fwd = (len < int'(MAXB)) ? len : int'(MAXB);
    for (int b = 0; b < len; b++) begin
      if (toSrc) begin
        if (src == 0) src0Q.push_back(mkBeat(src, pkt, b, b == len - 1));
        else          src1Q.push_back(mkBeat(src, pkt, b, b == len - 1));
      end
      if (toExp && b < fwd) expQ.push_back(mkBeat(src, pkt, b, b == fwd - 1));
    end
  endtask

  task automatic drive();
    inDataValid = '0;
    inDataLast  = '0;
    inData      = '0;
    if (src0Q.size() > 0) begin
      inDataValid[0] = 1'b1;
      inDataLast[0]  = src0Q[0][32];
      inData[31:0]   = src0Q[0][31:0];
    end
    if (src1Q.size() > 0) begin
      inDataValid[1] = 1'b1;
      inDataLast[1]  = src1Q[0][32];
      inData[63:32]  = src1Q[0][31:0];
    end
  endtask

  // One clock: sample at negedge, advance sources after the rising edge.
  task automatic cycle();
    logic [1:0]  acc;
    logic        outAcc;
    logic [32:0] e;
    @(negedge clk);
    acc    = inDataValid & inDataReady;
    outAcc = outDataValid & outDataReady;
    if (chkRdy && src1Q.size() > 0 && cyc > bpLoadCyc) begin
      checks++;
      if (inDataReady !== {outDataReady, 1'b0})
        $display("FAIL bp_ready cyc=%0d: got %b want %b", cyc, inDataReady, {outDataReady, 1'b0});
    end
    if (chkRdy && src1Q.size() > 0 && cyc > bpLoadCyc && inDataReady !== {outDataReady, 1'b0})
      errors++;
    if (outAcc) begin
      checks++;
      outBeats++;
      if (firstBeatCyc < 0) firstBeatCyc = cyc;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat cyc=%0d: got %h last=%b, want none", cyc, outData,
                 outDataLast);
      end else begin
        e = expQ.pop_front();
        if ({outDataLast, outData} !== e) begin
          errors++;
          $display("FAIL beat cyc=%0d: got %h want %h", cyc, {outDataLast, outData}, e);
        end
        checks++;
        if (grantIdx !== e[16]) begin
          errors++;
          $display("FAIL grant cyc=%0d: got %0d want %0d", cyc, grantIdx, e[16]);
        end
        if (chkGap && expectFirst && prevLastCyc >= 0) begin
          checks++;
          if (cyc - prevLastCyc != 2) begin
            errors++;
            $display("FAIL gap cyc=%0d: got %0d want 2", cyc, cyc - prevLastCyc);
          end
        end
      end
      expectFirst = outDataLast;
      if (outDataLast) prevLastCyc = cyc;
    end
    @(posedge clk);
    #1;
    if (acc[0]) void'(src0Q.pop_front());
    if (acc[1]) void'(src1Q.pop_front());
    if (toggleRdy) outDataReady = ~outDataReady;
    drive();
    cyc++;
  endtask

  task automatic runUntil(input int maxCyc, input bit waitSrc, input string name);
    int n;
    n = 0;
    while ((expQ.size() > 0 || (waitSrc && (src0Q.size() > 0 || src1Q.size() > 0)))
           && n < maxCyc) begin
      cycle();
      n++;
    end
    checks++;
    if (expQ.size() > 0 || (waitSrc && (src0Q.size() > 0 || src1Q.size() > 0))) begin
      errors++;
      $display("FAIL %s_timeout: got %0d beats outstanding, %0d/%0d source beats left, want 0",
               name, expQ.size(), src0Q.size(), src1Q.size());
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({inDataReady, outDataValid, outDataLast, busy, truncErr, grantIdx} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0", {inDataReady, outDataValid, outDataLast, busy,
               truncErr, grantIdx});
    end
    checks++;
    if (outData !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", outData);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_packet();
    int loadCyc;
    arbEnable    = 1'b1;
    firstBeatCyc = -1;
    loadCyc      = cyc;
    loadPkt(0, 0, 16, 1, 1);
    drive();
    runUntil(40, 1, "single");
    checks++;
    if (firstBeatCyc != loadCyc + 1) begin
      errors++;
      $display("FAIL first_beat_latency: got %0d want %0d", firstBeatCyc - loadCyc, 1);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_round_robin();
    // rrPtr is 1 after the single-source packet, so source 1 goes first.
    chkGap      = 1;
    prevLastCyc = -1;
    expectFirst = 1;
    loadPkt(1, 0, 4, 1, 1);
    loadPkt(0, 1, 4, 1, 1);
    loadPkt(1, 2, 4, 1, 1);
    loadPkt(0, 3, 4, 1, 1);
    drive();
    runUntil(60, 1, "round_robin");
    chkGap = 0;
  endtask

  task automatic test_backpressure();
    toggleRdy = 1;
    chkRdy    = 1;
    bpLoadCyc = cyc;
    loadPkt(1, 4, 8, 1, 1);
    drive();
    runUntil(60, 1, "backpressure");
    toggleRdy    = 0;
    chkRdy       = 0;
    outDataReady = 1'b1;
    drive();
  endtask

  task automatic test_truncation();
    checks++;
    if (truncErr !== 1'b0) begin
      errors++;
      $display("FAIL trunc_before: got %b want 0", truncErr);
    end
    loadPkt(0, 5, 20, 1, 1);
    drive();
    runUntil(80, 1, "truncation");
    checks++;
    if (truncErr !== 1'b1) begin
      errors++;
      $display("FAIL trunc_sticky: got %b want 1", truncErr);
    end
    // Both valid now; the grant must pass to source 1.
    loadPkt(1, 6, 2, 1, 1);
    loadPkt(0, 7, 2, 1, 1);
    drive();
    runUntil(20, 1, "after_trunc");
  endtask

  task automatic test_arb_enable();
    arbEnable = 1'b0;
    loadPkt(1, 8, 4, 1, 1);
    drive();
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if ({busy, inDataReady} !== 3'b000) begin
        errors++;
        $display("FAIL disabled_nogrant: got busy/ready=%b want 000", {busy, inDataReady});
      end
    end
    arbEnable = 1'b1;
    cycle();
    arbEnable = 1'b0;
    loadPkt(0, 9, 2, 1, 0);
    drive();
    runUntil(30, 0, "enable_mid_pkt");
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if ({busy, inDataReady} !== 3'b000) begin
        errors++;
        $display("FAIL disabled_after_pkt: got busy/ready=%b want 000", {busy, inDataReady});
      end
    end
    checks++;
    if (src0Q.size() != 2) begin
      errors++;
      $display("FAIL disabled_src0_held: got %0d beats left want 2", src0Q.size());
    end
    arbEnable = 1'b1;
    loadPkt(0, 9, 2, 0, 1);
    runUntil(20, 1, "reenable");
  endtask

  task automatic test_reset_midpacket();
    int n;
    outBeats = 0;
    n        = 0;
    loadPkt(1, 10, 10, 1, 1);
    drive();
    while (outBeats < 3 && n < 30) begin
      cycle();
      n++;
    end
    checks++;
    if (outBeats != 3) begin
      errors++;
      $display("FAIL midpkt_progress: got %0d beats want 3", outBeats);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({inDataReady, outDataValid, outDataLast, busy, truncErr, grantIdx} !== 7'b0) begin
      errors++;
      $display("FAIL async_reset_ctrl: got %b want 0", {inDataReady, outDataValid, outDataLast,
               busy, truncErr, grantIdx});
    end
    checks++;
    if (outData !== '0) begin
      errors++;
      $display("FAIL async_reset_data: got %h want 0", outData);
    end
    src0Q.delete();
    src1Q.delete();
    expQ.delete();
    expectFirst = 1;
    drive();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    // rrPtr is back to 0: source 0 wins the simultaneous request.
    loadPkt(0, 12, 2, 1, 1);
    loadPkt(1, 11, 2, 1, 1);
    drive();
    runUntil(20, 1, "post_reset");
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_truncation();
    test_arb_enable();
    test_reset_midpacket();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by %0t want finish", $time);
    $fatal(1);
  end

endmodule
